// File: rtl/out_buf.sv
// out_buf: FIFO staging buffer that releases words to the host in TILE-sized bursts.
// Define OUT_BUF_OVF_EN to add the sticky ovf output for writes dropped while full.
module out_buf #(
  parameter int WORDLEN = 8,
  parameter int BUFSIZE = 16,
  parameter int TILE = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [WORDLEN-1:0] din,
  output logic               full,
  output logic               empty,
  output logic [5:0]         count,
  input  logic               flush,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WORDLEN-1:0] m_data,
  output logic               m_last
`ifdef OUT_BUF_OVF_EN
  , output logic             ovf
`endif
);
  localparam int AW = $clog2(BUFSIZE);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [WORDLEN-1:0] mem [BUFSIZE];
  logic [AW-1:0] head, tail;
  logic [5:0] cnt, cnt_nx, len, len_nx, bcnt, bcnt_nx;
  logic flush_pend, fp_nx, wr, beat, go;
  assign wr = wr_en && !full;
  assign beat = m_valid && m_ready;
  assign full = cnt == 6'(BUFSIZE);
  assign empty = cnt == 6'd0;
  assign count = cnt;
  assign m_data = mem[head];
  assign m_valid = state == BURST;
  assign m_last = m_valid && bcnt == len - 6'd1;
  assign cnt_nx = cnt + 6'(wr) - 6'(beat);
  assign go = cnt >= 6'(TILE) || (flush_pend && !empty);
  always_comb begin
    state_nx = state;
    len_nx = len;
    bcnt_nx = bcnt;
    if (state == IDLE && go) begin
      state_nx = BURST;
      len_nx = cnt >= 6'(TILE) ? 6'(TILE) : cnt;
      bcnt_nx = 6'd0;
    end else if (beat) begin
      state_nx = m_last ? IDLE : BURST;
      bcnt_nx = m_last ? 6'd0 : bcnt + 6'd1;
    end
    // Clearing wins so a drained FIFO never leaves a stale flush behind.
    fp_nx = beat && m_last && cnt_nx == 6'd0 ? 1'b0 :
            flush && !(empty && state == IDLE) ? 1'b1 : flush_pend;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      cnt <= 6'd0;
      state <= IDLE;
      len <= 6'd0;
      bcnt <= 6'd0;
      flush_pend <= 1'b0;
    end else begin
      head <= head + AW'(beat);
      tail <= tail + AW'(wr);
      cnt <= cnt_nx;
      state <= state_nx;
      len <= len_nx;
      bcnt <= bcnt_nx;
      flush_pend <= fp_nx;
    end
  // Storage is cleared on reset so m_data reads zero while held in reset.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < BUFSIZE; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[tail] <= din;
    end
`ifdef OUT_BUF_OVF_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ovf <= 1'b0;
    else if (wr_en && full) ovf <= 1'b1;
`endif
endmodule

// File: tb/tb_out_buf.sv
// tb_out_buf: directed scoreboard bench for out_buf with default parameters.
module tb_out_buf;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] din = 8'd0;
  logic flush = 1'b0;
  logic m_ready = 1'b0;
  logic full, empty, m_valid, m_last;
  logic [5:0] count;
  logic [7:0] m_data;
`ifdef OUT_BUF_OVF_EN
  logic ovf;
`endif
  int errors = 0;
  int checks = 0;
  int mc = 0;
  int bi = 0;
  int el = 4;
  logic [7:0] exp_q [$];

  out_buf dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .din(din), .full(full), .empty(empty),
    .count(count), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
`ifdef OUT_BUF_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, score a beat if one will occur, advance, check count.
  task automatic step(input logic we, input logic [7:0] d, input logic rdy, input logic fl);
    logic acc, bt;
    logic [7:0] e;
    wr_en = we;
    din = d;
    m_ready = rdy;
    flush = fl;
    acc = we && mc < 16;
    bt = m_valid && rdy;
    if (bt) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(m_data), 32'hffff_ffff);
      end else begin
        e = exp_q.pop_front();
        check("m_data", 32'(m_data), 32'(e));
        check("m_last", 32'(m_last), 32'(bi == el - 1));
        bi = (bi == el - 1) ? 0 : bi + 1;
      end
    end
    if (acc) exp_q.push_back(d);
    mc = mc + int'(acc) - int'(bt);
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(mc));
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      step(1'b0, 8'd0, 1'b1, 1'b0);
      n++;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    rstn = 1'b1;
    step(1'b0, 8'd0, 1'b0, 1'b0);

    // basic burst
    el = 4;
    bi = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h11 + 8'(i), 1'b1, 1'b0);
    check("basic_no_valid_yet", 32'(m_valid), 32'd0);
    drain(20);
    check("basic_empty", 32'(empty), 32'd1);
    check("basic_valid_low", 32'(m_valid), 32'd0);

    // backpressure
    for (int i = 0; i < 4; i++) step(1'b1, 8'h21 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_data", 32'(m_data), 32'h21);
      step(1'b0, 8'd0, 1'b0, 1'b0);
    end
    drain(20);

    // flush of a partial tile
    el = 3;
    for (int i = 0; i < 3; i++) step(1'b1, 8'h31 + 8'(i), 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("flush_no_burst_before", 32'(m_valid), 32'd0);
    step(1'b0, 8'd0, 1'b1, 1'b1);
    drain(20);
    check("flush_pend_clear", 32'(dut.flush_pend), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 1'b1, 1'b0);
      check("flush_no_more_valid", 32'(m_valid), 32'd0);
    end

    // full and overflow
    el = 4;
    for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
`ifdef OUT_BUF_OVF_EN
    check("ovf_before", 32'(ovf), 32'd0);
`endif
    step(1'b1, 8'hee, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd16);
    check("full_flag", 32'(full), 32'd1);
`ifdef OUT_BUF_OVF_EN
    check("ovf_set", 32'(ovf), 32'd1);
`endif
    drain(40);
    check("full_drained_empty", 32'(empty), 32'd1);

    // wrap and concurrent write/beat
    for (int i = 0; i < 40; i++) step(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
    drain(60);
    check("wrap_empty", 32'(empty), 32'd1);

    // reset in the middle of a burst
    for (int i = 0; i < 4; i++) step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("mid_valid_before", 32'(m_valid), 32'd1);
    m_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    exp_q.delete();
    mc = 0;
    bi = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    check("post_rst_empty", 32'(empty), 32'd1);
    check("post_rst_valid", 32'(m_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
